// File: rtl/coin_pkg.sv
// Shared definitions for the coin inventory: denomination indices,
// default counter width and the dispense FSM state encoding.
package coin_pkg;

  localparam int NICKEL  = 0;
  localparam int DIME    = 1;
  localparam int QUARTER = 2;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } disp_state_e;

endpackage

// File: rtl/coin_slot_counter.sv
// Per-denomination coin counter: saturating increment, plain decrement,
// simultaneous inc and dec cancel. full/low are registered alongside value.
module coin_slot_counter #(
  parameter int CNT_W    = 8,
  parameter int LOW_MARK = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             full,
  output logic             low
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] r_value;
  logic             r_full;
  logic             r_low;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_next = r_value;
    if (inc && !dec && (r_value != MAX_VAL)) begin
      w_next = r_value + 1'b1;
    end else if (dec && !inc) begin
      w_next = r_value - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_full  <= 1'b0;
      r_low   <= 1'b1;
    end else begin
      r_value <= w_next;
      r_full  <= (w_next == MAX_VAL);
      r_low   <= (w_next <= CNT_W'(LOW_MARK));
    end
  end

  assign value = r_value;
  assign full  = r_full;
  assign low   = r_low;

endmodule

// File: rtl/coin_inventory.sv
// Coin inventory: per-type counters fed by the acceptor, plus a dispense FSM
// that checks coverage, then ejects one coin per cycle, lowest type first.
module coin_inventory
  import coin_pkg::*;
#(
  parameter int  NUM_TYPES = 3,
  parameter int  CNT_W     = CNT_W_DEFAULT,
  parameter int  LOW_MARK  = 2,
  localparam int TW        = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       coin_valid,
  input  logic [TW-1:0]              coin_type,
  input  logic                       disp_req,
  input  logic [NUM_TYPES*CNT_W-1:0] disp_qty,
  output logic                       disp_busy,
  output logic                       disp_done,
  output logic                       disp_err,
  output logic                       eject_valid,
  output logic [TW-1:0]              eject_type,
  output logic                       coin_reject,
  output logic [NUM_TYPES*CNT_W-1:0] count,
  output logic [NUM_TYPES-1:0]       low,
  output logic [NUM_TYPES-1:0]       full,
  output disp_state_e                dbg_state
);

  // Handshake: coin_valid is a single-cycle strobe qualified by enable and is
  // never back-pressured; disp_req is sampled only while disp_busy is low.

  disp_state_e          r_state;
  disp_state_e          w_state_next;
  logic [CNT_W-1:0]     r_remaining [NUM_TYPES];
  logic [NUM_TYPES-1:0] w_inc;
  logic [NUM_TYPES-1:0] w_dec;
  logic [NUM_TYPES-1:0] w_rej_full;
  logic                 w_deposit;
  logic                 w_type_ok;
  logic                 w_any;
  logic [TW-1:0]        w_sel;
  logic                 w_short;
  logic                 w_qty_zero;
  logic                 w_eject;
  logic                 w_load;

  logic                 r_busy, r_done, r_err, r_eject_valid, r_reject;
  logic [TW-1:0]        r_eject_type;
  logic                 w_busy_nx, w_done_nx, w_err_nx, w_ev_nx, w_rej_nx;
  logic [TW-1:0]        w_et_nx;

  assign w_deposit = enable && coin_valid;
  assign w_type_ok = (int'(coin_type) < NUM_TYPES);

  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_slot
    assign w_inc[t]      = w_deposit && (coin_type == TW'(t));
    assign w_dec[t]      = w_eject && (w_sel == TW'(t));
    // A full slot can still take a coin when the same slot ejects this edge.
    assign w_rej_full[t] = w_inc[t] && full[t] && !w_dec[t];

    coin_slot_counter #(
      .CNT_W    (CNT_W),
      .LOW_MARK (LOW_MARK)
    ) u_slot (
      .clock (clock),
      .reset (reset),
      .inc   (w_inc[t]),
      .dec   (w_dec[t]),
      .value (count[t*CNT_W +: CNT_W]),
      .full  (full[t]),
      .low   (low[t])
    );
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int t = NUM_TYPES - 1; t >= 0; t--) begin
      if (r_remaining[t] != '0) begin
        w_any = 1'b1;
        w_sel = TW'(t);
      end
    end
  end

  always_comb begin
    w_short    = 1'b0;
    w_qty_zero = 1'b1;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (disp_qty[t*CNT_W +: CNT_W] > count[t*CNT_W +: CNT_W]) w_short = 1'b1;
      if (disp_qty[t*CNT_W +: CNT_W] != '0) w_qty_zero = 1'b0;
    end
  end

  assign w_eject = (r_state == RUN) && w_any;
  assign w_load  = (r_state == IDLE) && disp_req && !w_short && !w_qty_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < NUM_TYPES; t++) r_remaining[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        if (w_load) begin
          r_remaining[t] <= disp_qty[t*CNT_W +: CNT_W];
        end else if (w_dec[t]) begin
          r_remaining[t] <= r_remaining[t] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_eject_valid <= 1'b0;
      r_eject_type  <= '0;
      r_reject      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
      r_err         <= w_err_nx;
      r_eject_valid <= w_ev_nx;
      r_eject_type  <= w_et_nx;
      r_reject      <= w_rej_nx;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (disp_req && !w_short) w_state_next = w_qty_zero ? DONE : RUN;
      end
      RUN:     if (!w_any) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port is a flop.
  always_comb begin
    w_busy_nx = (w_state_next != IDLE);
    w_done_nx = (w_state_next == DONE);
    w_err_nx  = (r_state == IDLE) && disp_req && w_short;
    w_ev_nx   = w_eject;
    w_et_nx   = w_eject ? w_sel : '0;
    w_rej_nx  = w_deposit && (!w_type_ok || (|w_rej_full));
  end

  assign disp_busy   = r_busy;
  assign disp_done   = r_done;
  assign disp_err    = r_err;
  assign eject_valid = r_eject_valid;
  assign eject_type  = r_eject_type;
  assign coin_reject = r_reject;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_coin_inventory.sv
// Bench for coin_inventory: directed scenarios plus random deposits/requests,
// checked against a per-type count model and an expected-eject scoreboard.
module tb_coin_inventory;
  import coin_pkg::*;

  localparam int NT  = 3;
  localparam int CW  = 8;
  localparam int TWB = 2;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             coin_valid;
  logic [TWB-1:0]   coin_type;
  logic             disp_req;
  logic [NT*CW-1:0] disp_qty;
  logic             disp_busy;
  logic             disp_done;
  logic             disp_err;
  logic             eject_valid;
  logic [TWB-1:0]   eject_type;
  logic             coin_reject;
  logic [NT*CW-1:0] count;
  logic [NT-1:0]    low;
  logic [NT-1:0]    full;
  disp_state_e      dbg_state;

  coin_inventory #(.NUM_TYPES(NT), .CNT_W(CW), .LOW_MARK(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .disp_req    (disp_req),
    .disp_qty    (disp_qty),
    .disp_busy   (disp_busy),
    .disp_done   (disp_done),
    .disp_err    (disp_err),
    .eject_valid (eject_valid),
    .eject_type  (eject_type),
    .coin_reject (coin_reject),
    .count       (count),
    .low         (low),
    .full        (full),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  logic [TWB-1:0] exp_eject_q[$];
  int exp_done_n;
  int exp_err_n;
  int exp_rej_n;
  int m[NT];
  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NT*CW-1:0] model_count();
    logic [NT*CW-1:0] v;
    for (int t = 0; t < NT; t++) v[t*CW +: CW] = CW'(m[t]);
    return v;
  endfunction

  function automatic logic [NT-1:0] model_low();
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = (m[t] <= 2);
    return v;
  endfunction

  function automatic logic [NT-1:0] model_full();
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = (m[t] == 255);
    return v;
  endfunction

  // Monitor: every output event must match a pending expectation
  always @(negedge clock) begin
    if (reset) begin
      if (eject_valid) begin
        check("eject_expected", 32'(exp_eject_q.size() > 0), 32'd1);
        if (exp_eject_q.size() > 0) check("eject_type", 32'(eject_type), 32'(exp_eject_q.pop_front()));
      end
      if (disp_done) begin
        check("done_expected", 32'(exp_done_n > 0), 32'd1);
        if (exp_done_n > 0) exp_done_n--;
      end
      if (disp_err) begin
        check("err_expected", 32'(exp_err_n > 0), 32'd1);
        if (exp_err_n > 0) exp_err_n--;
      end
      if (coin_reject) begin
        check("reject_expected", 32'(exp_rej_n > 0), 32'd1);
        if (exp_rej_n > 0) exp_rej_n--;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_count()));
    check({tag, "_low"}, 32'(low), 32'(model_low()));
    check({tag, "_full"}, 32'(full), 32'(model_full()));
  endtask

  task automatic deposit(input int t, input bit en);
    bit rej;
    rej = 1'b0;
    if (en) begin
      if (t >= NT) rej = 1'b1;
      else if (m[t] == 255) rej = 1'b1;
      else m[t]++;
    end
    if (rej) exp_rej_n++;
    enable     = en;
    coin_valid = 1'b1;
    coin_type  = TWB'(t);
    tick();
    coin_valid = 1'b0;
    check("reject_pulse", 32'(coin_reject), 32'(rej));
  endtask

  // Returns in cycle 1 after the request edge; busy_exp = expected busy cycles.
  task automatic issue_req(input int q0, input int q1, input int q2, output int busy_exp);
    int  q[NT];
    bit  short_f;
    bit  zero_f;
    q[0] = q0; q[1] = q1; q[2] = q2;
    short_f = 1'b0;
    zero_f  = 1'b1;
    for (int t = 0; t < NT; t++) begin
      if (q[t] > m[t]) short_f = 1'b1;
      if (q[t] != 0) zero_f = 1'b0;
    end
    if (short_f) begin
      exp_err_n++;
      busy_exp = 0;
    end else begin
      busy_exp = 2;
      for (int t = 0; t < NT; t++) begin
        for (int k = 0; k < q[t]; k++) exp_eject_q.push_back(TWB'(t));
        m[t] -= q[t];
        busy_exp += q[t];
      end
      if (zero_f) busy_exp = 1;
      exp_done_n++;
    end
    disp_qty = {CW'(q2), CW'(q1), CW'(q0)};
    disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    check("req_err", 32'(disp_err), 32'(short_f));
    check("req_busy", 32'(disp_busy), 32'(!short_f));
    check("req_no_eject_c1", 32'(eject_valid), 32'd0);
  endtask

  task automatic wait_idle(input int exp_cycles);
    int cycles;
    cycles = 0;
    while (disp_busy && cycles < 600) begin
      tick();
      cycles++;
    end
    check("busy_cycles", 32'(cycles), 32'(exp_cycles));
  endtask

  int be;

  initial begin
    reset = 1'b0; enable = 1'b0; coin_valid = 1'b0; coin_type = '0;
    disp_req = 1'b0; disp_qty = '0;
    exp_done_n = 0; exp_err_n = 0; exp_rej_n = 0; n_checks = 0; n_errors = 0;
    for (int t = 0; t < NT; t++) m[t] = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check_state("reset");
    check("reset_busy", 32'(disp_busy), 32'd0);
    check("reset_eject_type", 32'(eject_type), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // Deposits 3N 2D 1Q
    repeat (3) deposit(NICKEL, 1'b1);
    repeat (2) deposit(DIME, 1'b1);
    deposit(QUARTER, 1'b1);
    tick();
    check_state("deposit");

    // Mixed dispense, lowest type first
    issue_req(2, 1, 1, be);
    wait_idle(be);
    check_state("dispense");

    // Uncovered request
    issue_req(0, 5, 0, be);
    wait_idle(be);
    check_state("refused");

    // Saturate DIME, then overflow, then same-edge deposit + eject
    while (m[DIME] < 255) deposit(DIME, 1'b1);
    tick();
    check_state("saturated");
    deposit(DIME, 1'b1);
    issue_req(0, 1, 0, be);
    deposit(DIME, 1'b1);
    wait_idle(be - 1);
    check_state("same_edge");

    // Zero-quantity request, invalid type, disabled deposit
    issue_req(0, 0, 0, be);
    wait_idle(be);
    deposit(3, 1'b1);
    deposit(NICKEL, 1'b0);
    tick();
    check_state("zero_invalid");

    // Reset in cycle 3 of a 4-coin dispense
    repeat (3) deposit(NICKEL, 1'b1);
    issue_req(4, 0, 0, be);
    tick();
    tick();
    reset = 1'b0;
    exp_eject_q.delete();
    exp_done_n = 0;
    for (int t = 0; t < NT; t++) m[t] = 0;
    #2;
    check_state("midreset");
    check("midreset_state", 32'(dbg_state), 32'(IDLE));
    check("midreset_busy", 32'(disp_busy), 32'd0);
    check("midreset_eject", 32'(eject_valid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) tick();
    repeat (2) deposit(QUARTER, 1'b1);
    issue_req(0, 0, 2, be);
    wait_idle(be);
    check_state("post_reset");

    // Random deposits and requests
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        int t;
        t = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        deposit(t, ($urandom_range(0, 4) != 0));
      end else begin
        issue_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), be);
        wait_idle(be);
      end
      tick();
      check_state("rand");
    end

    repeat (3) tick();
    check("eject_q_drained", 32'(exp_eject_q.size()), 32'd0);
    check("done_drained", 32'(exp_done_n), 32'd0);
    check("err_drained", 32'(exp_err_n), 32'd0);
    check("reject_drained", 32'(exp_rej_n), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
